el2_lsu_dccm_wrbuf: RTL and testbench

EL2_LSU_DCCM_WRBUF -- requirements
Module: el2_lsu_dccm_wrbuf

---
 rtl/el2_pkg.sv | 35 +++
 rtl/el2_lib.sv | 18 +
 rtl/el2_lsu_wrbuf_hzd.sv | 29 ++
 rtl/el2_lsu_dccm_wrbuf.sv | 168 ++++++++++++++++
 tb/tb_el2_lsu_dccm_wrbuf.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/el2_pkg.sv
// el2_pkg: shared types for the LSU DCCM store write buffer.
// Holds the core parameter record (pt), the buffered store entry layout
// and the write-buffer drain FSM state encoding.
package el2_pkg;

  localparam int EL2_DCCM_BITS   = 16;
  localparam int EL2_FDATA_WIDTH = 39;

  // Core configuration record handed down as parameter pt.
  typedef struct packed {
    int unsigned DCCM_BITS;
    int unsigned FDATA_WIDTH;
  } el2_param_t;

  localparam el2_param_t EL2_PARAM_DEFAULT = '{DCCM_BITS: EL2_DCCM_BITS,
                                               FDATA_WIDTH: EL2_FDATA_WIDTH};

  // One committed store: both bank addresses plus data+ECC per bank.
  // Field widths follow the package defaults that pt is built from.
  typedef struct packed {
    logic [EL2_DCCM_BITS-1:0]   addr_lo;
    logic [EL2_DCCM_BITS-1:0]   addr_hi;
    logic [EL2_FDATA_WIDTH-1:0] data_lo;
    logic [EL2_FDATA_WIDTH-1:0] data_hi;
  } el2_dccm_wrbuf_entry_t;

  // IDLE: empty; WAIT: holding stores, loads own the port;
  // FORCE: stores own the port until one entry has drained.
  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_WAIT  = 2'd1,
    WB_FORCE = 2'd2
  } el2_wrbuf_state_t;

endpackage

// File: rtl/el2_lib.sv
// rvdff: plain D flop bank, asynchronous active-low clear to zero.
// Ports: din -> dout on clk rising edge; rst_l low clears dout at once.
// Latency 1 cycle; no enable, no backpressure.
module rvdff #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             clk,
  input  logic             rst_l,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) dout <= '0;
    else        dout <= din;
  end

endmodule

// File: rtl/el2_lsu_wrbuf_hzd.sv
// el2_lsu_wrbuf_hzd: word-address comparator between one buffered store and
// the current load (both banks against both banks). Combinational, 0 cycles.
// Ports: vld_i, entry_addr_lo_i/hi_i, ld_addr_lo_i/hi_i -> hit_o.
// Only present in builds with EL2_LSU_WRBUF_HAZARD_CHK_EN defined.
`ifdef EL2_LSU_WRBUF_HAZARD_CHK_EN
module el2_lsu_wrbuf_hzd #(
  parameter int AW = 16
) (
  input  logic          vld_i,
  input  logic [AW-1:0] entry_addr_lo_i,
  input  logic [AW-1:0] entry_addr_hi_i,
  input  logic [AW-1:0] ld_addr_lo_i,
  input  logic [AW-1:0] ld_addr_hi_i,
  output logic          hit_o
);

  // Byte offset within the 32-bit word is ignored: any overlap in the same
  // word is treated as a hazard.
  logic lo_lo, lo_hi, hi_lo, hi_hi;

  assign lo_lo = (entry_addr_lo_i[AW-1:2] == ld_addr_lo_i[AW-1:2]);
  assign lo_hi = (entry_addr_lo_i[AW-1:2] == ld_addr_hi_i[AW-1:2]);
  assign hi_lo = (entry_addr_hi_i[AW-1:2] == ld_addr_lo_i[AW-1:2]);
  assign hi_hi = (entry_addr_hi_i[AW-1:2] == ld_addr_hi_i[AW-1:2]);

  assign hit_o = vld_i & (lo_lo | lo_hi | hi_lo | hi_hi);

endmodule
`endif

// File: rtl/el2_lsu_dccm_wrbuf.sv
// el2_lsu_dccm_wrbuf: DEPTH-entry store write buffer in front of the DCCM
// write port; stores yield to loads until full or starved, then force a drain.
// Latency: an accepted store can drain the following cycle at the earliest.
// Backpressure: enq_ready = !wrbuf_full (registered); ld_stall holds loads
// off in FORCE or on an address hazard.
// Ports: clk, rst_l (async, active-low); enq_* store in; ld_* load probe /
// ld_stall; dccm_wren + dccm_wr_* write port; wrbuf_empty/full/count status.
// Build option EL2_LSU_WRBUF_HAZARD_CHK_EN: per-entry word-address compare;
// without it any non-empty buffer counts as a hazard for a load.
module el2_lsu_dccm_wrbuf
  import el2_pkg::*;
#(
  parameter el2_param_t pt         = EL2_PARAM_DEFAULT,
  parameter int         DEPTH      = 4,
  parameter int         STARVE_MAX = 8
) (
  input  logic                      clk,
  input  logic                      rst_l,

  input  logic                      enq_valid,
  output logic                      enq_ready,
  input  logic [pt.DCCM_BITS-1:0]   enq_addr_lo,
  input  logic [pt.DCCM_BITS-1:0]   enq_addr_hi,
  input  logic [pt.FDATA_WIDTH-1:0] enq_data_lo,
  input  logic [pt.FDATA_WIDTH-1:0] enq_data_hi,

  input  logic                      ld_rden,
  input  logic [pt.DCCM_BITS-1:0]   ld_addr_lo,
  input  logic [pt.DCCM_BITS-1:0]   ld_addr_hi,
  output logic                      ld_stall,

  output logic                      dccm_wren,
  output logic [pt.DCCM_BITS-1:0]   dccm_wr_addr_lo,
  output logic [pt.DCCM_BITS-1:0]   dccm_wr_addr_hi,
  output logic [pt.FDATA_WIDTH-1:0] dccm_wr_data_lo,
  output logic [pt.FDATA_WIDTH-1:0] dccm_wr_data_hi,

  output logic                      wrbuf_empty,
  output logic                      wrbuf_full,
  output logic [$clog2(DEPTH):0]    wrbuf_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX > 2) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

  // ---------------------------------------------------------------- state
  logic [1:0]        state_raw;
  el2_wrbuf_state_t  state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  rvdff #(.WIDTH(2))     u_state_ff  (.din(state_d),  .clk(clk), .rst_l(rst_l), .dout(state_raw));
  rvdff #(.WIDTH(CW))    u_count_ff  (.din(count_d),  .clk(clk), .rst_l(rst_l), .dout(count_q));
  rvdff #(.WIDTH(PW))    u_wrptr_ff  (.din(wr_ptr_d), .clk(clk), .rst_l(rst_l), .dout(wr_ptr_q));
  rvdff #(.WIDTH(PW))    u_rdptr_ff  (.din(rd_ptr_d), .clk(clk), .rst_l(rst_l), .dout(rd_ptr_q));
  rvdff #(.WIDTH(SW))    u_starve_ff (.din(starve_d), .clk(clk), .rst_l(rst_l), .dout(starve_q));
  rvdff #(.WIDTH(DEPTH)) u_valid_ff  (.din(valid_d),  .clk(clk), .rst_l(rst_l), .dout(valid_q));

  assign state_q = el2_wrbuf_state_t'(state_raw);

  // Entry storage needs no reset: nothing reads it unless its valid bit /
  // count says it was written, and the write-port outputs are gated.
  el2_dccm_wrbuf_entry_t mem_q [DEPTH];
  el2_dccm_wrbuf_entry_t enq_entry, head;

  assign enq_entry = '{addr_lo: enq_addr_lo, addr_hi: enq_addr_hi,
                       data_lo: enq_data_lo, data_hi: enq_data_hi};
  assign head      = mem_q[rd_ptr_q];

  // ---------------------------------------------------------- handshakes
  logic enq, drain, blocked, hazard;

  assign wrbuf_empty = (count_q == '0);
  assign wrbuf_full  = (count_q == DEPTH_C);
  assign wrbuf_count = count_q;
  assign enq_ready   = !wrbuf_full;
  assign enq         = enq_valid & enq_ready;

  // Emptiness comes from the registered count, so a store accepted this
  // cycle is never written through in the same cycle.
  assign drain   = !wrbuf_empty & (!ld_rden | (state_q == WB_FORCE));
  assign blocked = (state_q == WB_WAIT) & ld_rden & !wrbuf_empty;

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= enq_entry;
  end

  // -------------------------------------------------------------- hazard
`ifdef EL2_LSU_WRBUF_HAZARD_CHK_EN
  logic [DEPTH-1:0] hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_hzd
    el2_lsu_wrbuf_hzd #(.AW(pt.DCCM_BITS)) u_hzd (
      .vld_i           (valid_q[i]),
      .entry_addr_lo_i (mem_q[i].addr_lo),
      .entry_addr_hi_i (mem_q[i].addr_hi),
      .ld_addr_lo_i    (ld_addr_lo),
      .ld_addr_hi_i    (ld_addr_hi),
      .hit_o           (hit[i])
    );
  end

  assign hazard = |hit;
`else
  // No comparators: any buffered store may alias the load.
  logic unused_ld_addr;

  assign unused_ld_addr = ^{ld_addr_lo, ld_addr_hi};
  assign hazard         = !wrbuf_empty;
`endif

  assign ld_stall = ld_rden & ((state_q == WB_FORCE) | hazard);

  // ---------------------------------------------------- pointers / count
  always_comb begin
    wr_ptr_d = enq   ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = drain ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Enqueue and drain never target the same slot: enqueue needs a free
    // slot, drain needs a filled one.
    valid_d = valid_q;
    if (enq)   valid_d[wr_ptr_q] = 1'b1;
    if (drain) valid_d[rd_ptr_q] = 1'b0;
  end

  // --------------------------------------------------------- starvation
  always_comb begin
    starve_d = starve_q;
    if (drain)                                 starve_d = '0;
    else if (blocked && starve_q != STARVE_LAST) starve_d = starve_q + SW'(1);
  end

  // ----------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE:  if (enq) state_d = WB_WAIT;
      // Going to FORCE on the next count lets the store win the port in the
      // first cycle the buffer is full.
      WB_WAIT:  if ((count_d == DEPTH_C) || (blocked && starve_q == STARVE_LAST))
                  state_d = WB_FORCE;
      WB_FORCE: if (drain && (count_d != DEPTH_C)) state_d = WB_WAIT;
      default:  state_d = WB_IDLE;
    endcase
    if (count_d == '0) state_d = WB_IDLE;
  end

  // ------------------------------------------------------ DCCM write port
  assign dccm_wren       = drain;
  assign dccm_wr_addr_lo = dccm_wren ? head.addr_lo : '0;
  assign dccm_wr_addr_hi = dccm_wren ? head.addr_hi : '0;
  assign dccm_wr_data_lo = dccm_wren ? head.data_lo : '0;
  assign dccm_wr_data_hi = dccm_wren ? head.data_hi : '0;

endmodule

// File: tb/tb_el2_lsu_dccm_wrbuf.sv
module tb_el2_lsu_dccm_wrbuf;

  localparam logic [15:0] Z16 = 16'h0000;
  localparam logic [15:0] LNM = 16'h0F00;   // load address matching nothing stored
  localparam logic [38:0] Z39 = 39'h0;

`ifdef EL2_LSU_WRBUF_HAZARD_CHK_EN
  localparam logic HZ = 1'b1;
`else
  localparam logic HZ = 1'b0;
`endif
  // Stall seen by a load at a non-matching address while stores are held.
  localparam logic NMS = ~HZ;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        enq_valid;
  logic        enq_ready;
  logic [15:0] enq_addr_lo, enq_addr_hi;
  logic [38:0] enq_data_lo, enq_data_hi;
  logic        ld_rden;
  logic [15:0] ld_addr_lo, ld_addr_hi;
  logic        ld_stall;
  logic        dccm_wren;
  logic [15:0] dccm_wr_addr_lo, dccm_wr_addr_hi;
  logic [38:0] dccm_wr_data_lo, dccm_wr_data_hi;
  logic        wrbuf_empty, wrbuf_full;
  logic [2:0]  wrbuf_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  el2_lsu_dccm_wrbuf dut (
    .clk             (clk),
    .rst_l           (rst_l),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_addr_lo     (enq_addr_lo),
    .enq_addr_hi     (enq_addr_hi),
    .enq_data_lo     (enq_data_lo),
    .enq_data_hi     (enq_data_hi),
    .ld_rden         (ld_rden),
    .ld_addr_lo      (ld_addr_lo),
    .ld_addr_hi      (ld_addr_hi),
    .ld_stall        (ld_stall),
    .dccm_wren       (dccm_wren),
    .dccm_wr_addr_lo (dccm_wr_addr_lo),
    .dccm_wr_addr_hi (dccm_wr_addr_hi),
    .dccm_wr_data_lo (dccm_wr_data_lo),
    .dccm_wr_data_hi (dccm_wr_data_hi),
    .wrbuf_empty     (wrbuf_empty),
    .wrbuf_full      (wrbuf_full),
    .wrbuf_count     (wrbuf_count)
  );

  typedef struct {
    logic        enq;
    logic [15:0] alo, ahi;
    logic [38:0] dlo, dhi;
    logic        ldr;
    logic [15:0] llo, lhi;
    logic        xw;
    logic [15:0] xalo, xahi;
    logic [38:0] xdlo, xdhi;
    logic        xst, xrdy, xemp, xfull;
    logic [2:0]  xcnt;
  } vec_t;

  // Stored data_hi is always data_lo + 1, so the expected hi data follows.
  function automatic vec_t mk(
    input logic enq, input logic [15:0] alo, input logic [15:0] ahi,
    input logic [38:0] d, input logic ldr, input logic [15:0] llo,
    input logic [15:0] lhi, input logic xw, input logic [15:0] xalo,
    input logic [15:0] xahi, input logic [38:0] xd, input logic xst,
    input logic xrdy, input logic xemp, input logic xfull, input logic [2:0] xcnt);
    vec_t v;
    v.enq = enq; v.alo = alo; v.ahi = ahi; v.dlo = d; v.dhi = d + 39'd1;
    v.ldr = ldr; v.llo = llo; v.lhi = lhi;
    v.xw = xw; v.xalo = xalo; v.xahi = xahi; v.xdlo = xd;
    v.xdhi = xw ? xd + 39'd1 : Z39;
    v.xst = xst; v.xrdy = xrdy; v.xemp = xemp; v.xfull = xfull; v.xcnt = xcnt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    enq_valid   = v.enq;
    enq_addr_lo = v.alo;
    enq_addr_hi = v.ahi;
    enq_data_lo = v.dlo;
    enq_data_hi = v.dhi;
    ld_rden     = v.ldr;
    ld_addr_lo  = v.llo;
    ld_addr_hi  = v.lhi;
  endtask

  task automatic check(input vec_t v, input string tag);
    n_vec++;
    if ({dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo, dccm_wr_data_hi,
         ld_stall, enq_ready, wrbuf_empty, wrbuf_full, wrbuf_count} !==
        {v.xw, v.xalo, v.xahi, v.xdlo, v.xdhi, v.xst, v.xrdy, v.xemp, v.xfull, v.xcnt}) begin
      n_err++;
      $display("FAIL %s: got wren=%b a=%h/%h d=%h/%h stall=%b rdy=%b emp=%b full=%b cnt=%0d, want wren=%b a=%h/%h d=%h/%h stall=%b rdy=%b emp=%b full=%b cnt=%0d",
               tag, dccm_wren, dccm_wr_addr_lo, dccm_wr_addr_hi, dccm_wr_data_lo,
               dccm_wr_data_hi, ld_stall, enq_ready, wrbuf_empty, wrbuf_full, wrbuf_count,
               v.xw, v.xalo, v.xahi, v.xdlo, v.xdhi, v.xst, v.xrdy, v.xemp, v.xfull, v.xcnt);
    end
  endtask

  // Drive after the rising edge, compare on the falling edge, then clock.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check(v, tag);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];
  vec_t idle_v;
  vec_t v;

  initial begin
    idle_v = mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);

    // Single store, no loads: written the next cycle, then empty.
    tbl.push_back(idle_v);
    tbl.push_back(mk(1'b1, 16'h0104, 16'h0104, 39'h5A, 1'b0, Z16, Z16,
                     1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                     1'b1, 16'h0104, 16'h0104, 39'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(idle_v);

    // Four stores under continuous loads: fill, FORCE one drain, back to WAIT.
    tbl.push_back(mk(1'b1, 16'h0010, 16'h0010, 39'h11, 1'b1, LNM, LNM,
                     1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 16'h0020, 16'h0020, 39'h22, 1'b1, LNM, LNM,
                     1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b1, 16'h0030, 16'h0030, 39'h33, 1'b1, LNM, LNM,
                     1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd2));
    tbl.push_back(mk(1'b1, 16'h0040, 16'h0040, 39'h44, 1'b1, LNM, LNM,
                     1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd3));
    tbl.push_back(mk(1'b1, 16'h0050, 16'h0050, 39'h55, 1'b1, LNM, LNM,
                     1'b1, 16'h0010, 16'h0010, 39'h11, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b1, LNM, LNM,
                     1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd3));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                     1'b1, 16'h0020, 16'h0020, 39'h22, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                     1'b1, 16'h0030, 16'h0030, 39'h33, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                     1'b1, 16'h0040, 16'h0040, 39'h44, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(idle_v);

    // Misaligned store, then enqueue during a drain (count holds at 1).
    tbl.push_back(mk(1'b1, 16'h01FC, 16'h0200, 39'h12_3456_789A, 1'b0, Z16, Z16,
                     1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 16'h0300, 16'h0300, 39'h66, 1'b0, Z16, Z16,
                     1'b1, 16'h01FC, 16'h0200, 39'h12_3456_789A, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                     1'b1, 16'h0300, 16'h0300, 39'h66, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(idle_v);

    // Hazard: same-word load on hi, non-matching load, same-word load on lo.
    tbl.push_back(mk(1'b1, 16'h0200, 16'h0200, 39'h99, 1'b0, Z16, Z16,
                     1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b1, LNM, 16'h0202,
                     1'b0, Z16, Z16, Z39, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b1, 16'h0300, 16'h0300,
                     1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b1, 16'h0203, LNM,
                     1'b0, Z16, Z16, Z39, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
                     1'b1, 16'h0200, 16'h0200, 39'h99, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1));
    tbl.push_back(idle_v);

    // Reset and reset-state check.
    drive(idle_v);
    rst_l = 1'b1;
    #2 rst_l = 1'b0;
    #1 check(idle_v, "reset_state");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_l = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Starvation: one entry, load held on a non-matching address.
    apply(mk(1'b1, 16'h0400, 16'h0400, 39'hAB, 1'b0, Z16, Z16,
             1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0), "starve_enq");
    for (int k = 0; k < 10; k++) begin
      apply(mk(1'b0, Z16, Z16, Z39, 1'b1, LNM, LNM,
               (k == 8), (k == 8) ? 16'h0400 : Z16, (k == 8) ? 16'h0400 : Z16,
               (k == 8) ? 39'hAB : Z39,
               HZ ? (k == 8) : (k <= 8),
               1'b1, (k == 9), 1'b0, (k == 9) ? 3'd0 : 3'd1),
            $sformatf("starve[%0d]", k));
    end

    // Reset in the middle of draining three entries.
    apply(mk(1'b1, 16'h0500, 16'h0500, 39'h51, 1'b1, LNM, LNM,
             1'b0, Z16, Z16, Z39, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0), "mid_fill0");
    apply(mk(1'b1, 16'h0504, 16'h0504, 39'h52, 1'b1, LNM, LNM,
             1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd1), "mid_fill1");
    apply(mk(1'b1, 16'h0508, 16'h0508, 39'h53, 1'b1, LNM, LNM,
             1'b0, Z16, Z16, Z39, NMS, 1'b1, 1'b0, 1'b0, 3'd2), "mid_fill2");
    v = mk(1'b0, Z16, Z16, Z39, 1'b0, Z16, Z16,
           1'b1, 16'h0500, 16'h0500, 39'h51, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3);
    drive(v);
    @(negedge clk);
    check(v, "mid_drain");
    #1 rst_l = 1'b0;
    #1 check(idle_v, "mid_rst_async");
    @(posedge clk);
    #1 check(idle_v, "mid_rst_held");
    @(negedge clk) rst_l = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) apply(idle_v, $sformatf("post_rst[%0d]", k));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
